// File: rtl/extruder_type_detector.sv
// Extruder type detector: conditions the raw extruder-ID pin from the toolhead
// connector into a clean, debounced 1-bit type for the HPS PIO input port.
// Path: 2-flop synchronizer -> debounce FSM -> registered type. Also flags
// type changes committed during a print (hot-swap fault) and counts commits.
//
// DEBOUNCE_CYCLES must be >= 2 and 2**CNT_W must exceed DEBOUNCE_CYCLES.
// Debounce counter meaning: cnt holds how many consecutive samples of the
// level being tracked have already been seen, including the current one once
// it is registered. A level is committed on the edge that delivers its
// DEBOUNCE_CYCLES-th consecutive sample.
module extruder_type_detector #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ext_id_raw,
  input  logic       print_active,
  input  logic       fault_clear,
  output logic       type_out,
  output logic       type_valid,
  output logic       type_changed,
  output logic       hotswap_fault,
  output logic [7:0] change_count
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_STABLE   = 2'd1,
    ST_DEBOUNCE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state_q, state_d;
  logic             sync1_q;
  logic             sync_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cand_q, cand_d;
  logic             type_q, type_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic             fault_q, fault_d;
  logic [7:0]       count_q, count_d;

  // Saturating increment for the diagnostic change counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Two-flop synchronizer for the asynchronous raw pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync_s_q <= 1'b0;
    end else begin
      sync1_q  <= ext_id_raw;
      sync_s_q <= sync1_q;
    end
  end

  // Debounce FSM state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      cand_q    <= 1'b0;
      type_q    <= 1'b0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      fault_q   <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      type_q    <= type_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      fault_q   <= fault_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic: acquire the first level, then track and commit changes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    type_d    = type_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    count_d   = count_q;
    // A clear pulse drops the fault unless a faulting commit sets it below.
    fault_d   = fault_q & ~fault_clear;

    case (state_q)
      ST_INIT: begin
        if (sync_s_q != cand_q) begin
          // New candidate; this sample is the first of its run.
          cand_d = sync_s_q;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          // Initial acquisition: not reported as a change.
          type_d  = cand_q;
          valid_d = 1'b1;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STABLE: begin
        if (sync_s_q != type_q) begin
          cnt_d   = CNT_ONE;
          state_d = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (sync_s_q == type_q) begin
          // Glitch rejected; the committed level never moved.
          cnt_d   = CNT_ZERO;
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          type_d    = sync_s_q;
          changed_d = 1'b1;
          count_d   = sat_inc8(count_q);
          if (print_active) begin
            fault_d = 1'b1;
          end
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_INIT;
      end
    endcase
  end

  assign type_out      = type_q;
  assign type_valid    = valid_q;
  assign type_changed  = changed_q;
  assign hotswap_fault = fault_q;
  assign change_count  = count_q;

endmodule
